counter_mod_cascade: RTL and testbench
======================================

Name: counter_mod_cascade

Overview:
- Parametrised successor to the single-digit modulo counter: a chain of DIGITS modulo-BASE digit counters with ripple carry/borrow.
- Adds up/down counting, parallel load, wrap or saturate mode, and a terminal-count pulse.
- Sits between the dispenser control FSM and the display/timer logic. Drives countdown timers for feeding intervals and up-counters for portion tallies.
- Keeps the two-stage structure: internal count register plus registered output stage, so count_out lags the internal count by one cycle.

Parameters:
- DIGITS, 2, number of cascaded digits (1..8)
- BASE, 10, modulus of every digit (2..2^DW)
- DW, 4, bits per digit; must hold BASE-1
- WRAP, 1, 1 = wrap at boundary, 0 = saturate at boundary

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  count one step this cycle
- up_down  in  1  1 = count up, 0 = count down; sampled when enable=1
- load  in  1  parallel load request; priority over enable
- load_value  in  DIGITS*DW  digit i at bits [i*DW +: DW]; digit 0 is least significant
- count_out  out  DIGITS*DW  registered copy of the internal count, same packing
- zero  out  1  high when count_out is all-zero
- tc_pulse  out  1  one-cycle pulse aligned with count_out, marks a boundary event
- carry_out  out  1  combinational; high when enable=1 and the current step crosses a boundary (for chaining)

Behaviour:
- Reset (reset=0, asynchronous): internal count = 0, count_out = 0, tc_pulse = 0, zero = 1. Release is synchronous to clk; the first step can occur on the first edge after release.
- Priority each edge: load > enable > hold.
- Load:
  - each digit is taken from load_value; any digit >= BASE is clamped to BASE-1;
  - no tc_pulse is generated;
  - count_out shows the loaded value one cycle later.
- Up step:
  - digit 0 increments;
  - digit i increments only when all lower digits equal BASE-1;
  - a digit at BASE-1 that increments becomes 0.
- Down step:
  - digit 0 decrements;
  - digit i decrements only when all lower digits equal 0;
  - a digit at 0 that decrements becomes BASE-1.
- Boundary event: an enabled up step from all digits = BASE-1, or an enabled down step from all digits = 0.
  - WRAP=1: the count wraps to all-zero (up) or all-(BASE-1) (down).
  - WRAP=0: the count holds its value.
  - In both modes: carry_out = 1 that cycle, and tc_pulse = 1 for exactly one cycle on the following edge, aligned with count_out.
- Saturate mode (WRAP=0): every enabled step at the boundary produces a tc_pulse, so repeated attempts give repeated pulses.
- Latency: count_out = internal count delayed by 1 clk. zero is derived combinationally from count_out.
- up_down changes while enable=0 have no effect.
- Load and enable in the same cycle: the load wins, the step is discarded, and no tc_pulse is generated even if a step would have crossed the boundary.
- Reset asserted mid-operation: all state clears immediately, independent of clk.
- Arithmetic is per digit modulo BASE. There is no binary overflow path; the widths are exact.

Optional Feature:
- Macro: CNTM_FREEZE_EN.
- Defined:
  - adds input port freeze (1 bit);
  - while freeze=1, count_out and tc_pulse registers hold their values (tc_pulse forced 0 after its current cycle), while the internal count keeps stepping and loading;
  - on freeze deassertion, count_out resumes tracking one cycle later;
  - a boundary event that occurs during freeze is still reported by carry_out but produces no tc_pulse.
- Undefined: no freeze port; behaviour exactly as above.

Test Plan (DIGITS=2, BASE=10, DW=4):
- Reset, then enable=1, up_down=1 for 100 cycles -> count_out steps 00..99 then 00, lagging the internal count by one cycle; tc_pulse high exactly once, in the cycle count_out shows 00; carry_out high in the 99->00 step cycle.
- Load 0x05, then enable=1, up_down=0 for 7 cycles, WRAP=1 -> count_out 05,04,03,02,01,00,99; tc_pulse aligned with 99; zero high only while count_out=00.
- WRAP=0: load 0x01, down for 4 cycles -> count_out 01,00,00,00; tc_pulse high on each of the 3 cycles after the attempted steps below zero.
- load=1 with load_value 0xA3 and enable=1 in the same cycle -> count_out=0x93 next cycle (digit 1 clamped), no tc_pulse, no step applied.
- Count up to 0x47, assert reset low between clock edges -> count_out=00, zero=1, tc_pulse=0 immediately; after release, the first enabled up edge gives 01 one cycle later.
- With CNTM_FREEZE_EN: count up, freeze=1 at count_out=0x12 for 5 cycles -> count_out stays 0x12; after release it shows 0x18 one cycle later.

Source files
------------

// File: rtl/counter_mod_cascade_if.sv
// Control/status bundle between the dispenser controller and the cascaded counter.
// The freeze signal exists only when CNTM_FREEZE_EN is defined.
interface counter_mod_cascade_if #(
   parameter int unsigned DIGITS = 2,
   parameter int unsigned DW     = 4
);
   logic                   enable;
   logic                   up_down;
   logic                   load;
   logic [DIGITS*DW-1:0]   load_value;
   logic [DIGITS*DW-1:0]   count_out;
   logic                   zero;
   logic                   tc_pulse;
   logic                   carry_out;
`ifdef CNTM_FREEZE_EN
   logic                   freeze;
`endif

   modport master (
`ifdef CNTM_FREEZE_EN
      output freeze,
`endif
      output enable, up_down, load, load_value,
      input  count_out, zero, tc_pulse, carry_out
   );

   modport slave (
`ifdef CNTM_FREEZE_EN
      input  freeze,
`endif
      input  enable, up_down, load, load_value,
      output count_out, zero, tc_pulse, carry_out
   );
endinterface

// File: rtl/counter_mod_cascade.sv
// Cascade of DIGITS modulo-BASE digit counters (up/down, load, wrap/saturate) with a
// registered output stage. Optional output freeze is enabled by defining CNTM_FREEZE_EN.
module counter_mod_cascade #(
   parameter int unsigned DIGITS = 2,
   parameter int unsigned BASE   = 10,
   parameter int unsigned DW     = 4,
   parameter int unsigned WRAP   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   counter_mod_cascade_if.slave  bus
);
   localparam int unsigned        W     = DIGITS * DW;
   localparam int unsigned        DW1   = DW + 1;
   localparam logic [DW-1:0]      DMAX  = DW'(BASE - 1);
   localparam logic [DW1-1:0]     DBASE = DW1'(BASE);

   logic [W-1:0] cnt;
   logic [W-1:0] cnt_nxt;
   logic [W-1:0] count_q;
   logic         bnd_q;
   logic         bnd_nxt;
   logic         tc_q;
   logic         all_max;
   logic         all_zero;
   logic         at_bound;
   logic         boundary;
   logic         ripple;

   // Boundary detection on the internal count
   always_comb begin : detect_bound
      all_max  = 1'b1;
      all_zero = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (cnt[i*DW +: DW] != DMAX) all_max  = 1'b0;
         if (cnt[i*DW +: DW] != '0)   all_zero = 1'b0;
      end
   end

   assign at_bound      = bus.up_down ? all_max : all_zero;
   assign boundary      = bus.enable & ~bus.load & at_bound;
   assign bus.carry_out = boundary;

   // Next internal count: load (with clamp) beats step; a digit steps only when all lower digits rolled
   always_comb begin : next_count
      cnt_nxt = cnt;
      ripple  = 1'b1;
      if (bus.load) begin
         for (int unsigned i = 0; i < DIGITS; i++) begin
            cnt_nxt[i*DW +: DW] = ({1'b0, bus.load_value[i*DW +: DW]} >= DBASE)
                                  ? DMAX : bus.load_value[i*DW +: DW];
         end
      end else if (bus.enable && !(boundary && (WRAP == 0))) begin
         for (int unsigned i = 0; i < DIGITS; i++) begin
            if (ripple) begin
               if (bus.up_down) begin
                  cnt_nxt[i*DW +: DW] = (cnt[i*DW +: DW] == DMAX) ? '0 : cnt[i*DW +: DW] + DW'(1);
               end else begin
                  cnt_nxt[i*DW +: DW] = (cnt[i*DW +: DW] == '0) ? DMAX : cnt[i*DW +: DW] - DW'(1);
               end
            end
            ripple = ripple & (bus.up_down ? (cnt[i*DW +: DW] == DMAX)
                                           : (cnt[i*DW +: DW] == '0));
         end
      end
   end

`ifdef CNTM_FREEZE_EN
   assign bnd_nxt = boundary & ~bus.freeze;
`else
   assign bnd_nxt = boundary;
`endif

   // Internal stage: count plus a pending boundary flag that travels with it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt   <= '0;
         bnd_q <= 1'b0;
      end else begin
         cnt   <= cnt_nxt;
         bnd_q <= bnd_nxt;
      end
   end

   // Output stage: one cycle behind the internal stage so tc_pulse lines up with the wrapped value
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
`ifdef CNTM_FREEZE_EN
         if (bus.freeze) begin
            tc_q <= 1'b0;
         end else begin
            count_q <= cnt;
            tc_q    <= bnd_q;
         end
`else
         count_q <= cnt;
         tc_q    <= bnd_q;
`endif
      end
   end

   assign bus.count_out = count_q;
   assign bus.tc_pulse  = tc_q;
   assign bus.zero      = (count_q == '0);
endmodule

// File: tb/tb_counter_mod_cascade.sv
// Directed bench for counter_mod_cascade: a wrapping and a saturating instance driven in parallel.
// The freeze scenario is compiled in only with CNTM_FREEZE_EN.
module tb_counter_mod_cascade;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   counter_mod_cascade_if #(.DIGITS(2), .DW(4)) ifw ();
   counter_mod_cascade_if #(.DIGITS(2), .DW(4)) ifs ();

   counter_mod_cascade #(.DIGITS(2), .BASE(10), .DW(4), .WRAP(1)) dut_w (
      .clk(clk), .reset(reset), .bus(ifw));
   counter_mod_cascade #(.DIGITS(2), .BASE(10), .DW(4), .WRAP(0)) dut_s (
      .clk(clk), .reset(reset), .bus(ifs));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] bcd(input int n);
      bcd = {4'(n / 10), 4'(n % 10)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic ld, input logic [7:0] lv, input logic en, input logic ud);
      ifw.load = ld; ifw.load_value = lv; ifw.enable = en; ifw.up_down = ud;
      ifs.load = ld; ifs.load_value = lv; ifs.enable = en; ifs.up_down = ud;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      checks++; if (ifw.count_out !== 8'h00) begin failures++; $display("FAIL reset_count_w got=%h exp=00", ifw.count_out); end
      checks++; if (ifw.zero !== 1'b1) begin failures++; $display("FAIL reset_zero_w got=%b exp=1", ifw.zero); end
      checks++; if (ifw.tc_pulse !== 1'b0) begin failures++; $display("FAIL reset_tc_w got=%b exp=0", ifw.tc_pulse); end
      checks++; if (ifs.count_out !== 8'h00) begin failures++; $display("FAIL reset_count_s got=%h exp=00", ifs.count_out); end
      checks++; if (ifs.zero !== 1'b1) begin failures++; $display("FAIL reset_zero_s got=%b exp=1", ifs.zero); end
      reset = 1'b1;
   endtask

   task automatic test_count_up();
      int m;
      logic [7:0] prev;
      m = 0;
      drive(1'b0, 8'h00, 1'b1, 1'b1);
      for (int k = 0; k <= 100; k++) begin
         checks++; if (ifw.carry_out !== (m == 99)) begin failures++; $display("FAIL up_carry k=%0d got=%b exp=%b", k, ifw.carry_out, (m == 99)); end
         prev = bcd(m);
         tick();
         m = (m + 1) % 100;
         checks++; if (ifw.count_out !== prev) begin failures++; $display("FAIL up_count k=%0d got=%h exp=%h", k, ifw.count_out, prev); end
         checks++; if (ifw.tc_pulse !== (k == 100)) begin failures++; $display("FAIL up_tc k=%0d got=%b exp=%b", k, ifw.tc_pulse, (k == 100)); end
         #1;
      end
      drive(1'b0, 8'h00, 1'b0, 1'b1);
   endtask

   task automatic test_down_wrap();
      logic [7:0] exp_seq [7];
      exp_seq = '{8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h99};
      drive(1'b1, 8'h05, 1'b0, 1'b0);
      tick();
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      for (int k = 1; k <= 7; k++) begin
         tick();
         checks++; if (ifw.count_out !== exp_seq[k-1]) begin failures++; $display("FAIL down_count k=%0d got=%h exp=%h", k, ifw.count_out, exp_seq[k-1]); end
         checks++; if (ifw.tc_pulse !== (k == 7)) begin failures++; $display("FAIL down_tc k=%0d got=%b exp=%b", k, ifw.tc_pulse, (k == 7)); end
         checks++; if (ifw.zero !== (k == 6)) begin failures++; $display("FAIL down_zero k=%0d got=%b exp=%b", k, ifw.zero, (k == 6)); end
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic test_saturate();
      logic [7:0] exp_cnt [4];
      logic       exp_tc  [4];
      logic       exp_cy  [4];
      exp_cnt = '{8'h01, 8'h00, 8'h00, 8'h00};
      exp_tc  = '{1'b0, 1'b0, 1'b1, 1'b1};
      exp_cy  = '{1'b0, 1'b1, 1'b1, 1'b1};
      drive(1'b1, 8'h01, 1'b0, 1'b0);
      tick();
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      for (int k = 0; k < 4; k++) begin
         checks++; if (ifs.carry_out !== exp_cy[k]) begin failures++; $display("FAIL sat_carry k=%0d got=%b exp=%b", k, ifs.carry_out, exp_cy[k]); end
         tick();
         checks++; if (ifs.count_out !== exp_cnt[k]) begin failures++; $display("FAIL sat_count k=%0d got=%h exp=%h", k, ifs.count_out, exp_cnt[k]); end
         checks++; if (ifs.tc_pulse !== exp_tc[k]) begin failures++; $display("FAIL sat_tc k=%0d got=%b exp=%b", k, ifs.tc_pulse, exp_tc[k]); end
         #1;
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      checks++; if (ifs.tc_pulse !== 1'b1) begin failures++; $display("FAIL sat_tc_last got=%b exp=1", ifs.tc_pulse); end
      checks++; if (ifs.count_out !== 8'h00) begin failures++; $display("FAIL sat_hold got=%h exp=00", ifs.count_out); end
      tick();
      checks++; if (ifs.tc_pulse !== 1'b0) begin failures++; $display("FAIL sat_tc_end got=%b exp=0", ifs.tc_pulse); end
   endtask

   task automatic test_load_clamp();
      drive(1'b1, 8'h99, 1'b0, 1'b1);
      tick();
      drive(1'b1, 8'hA3, 1'b1, 1'b1);
      tick();
      checks++; if (ifw.count_out !== 8'h99) begin failures++; $display("FAIL load_first got=%h exp=99", ifw.count_out); end
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      tick();
      checks++; if (ifw.count_out !== 8'h93) begin failures++; $display("FAIL load_clamp got=%h exp=93", ifw.count_out); end
      checks++; if (ifw.tc_pulse !== 1'b0) begin failures++; $display("FAIL load_tc got=%b exp=0", ifw.tc_pulse); end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      checks++; if (ifw.count_out !== 8'h93) begin failures++; $display("FAIL hold_updown got=%h exp=93", ifw.count_out); end
      checks++; if (ifw.tc_pulse !== 1'b0) begin failures++; $display("FAIL load_tc2 got=%b exp=0", ifw.tc_pulse); end
      tick();
      checks++; if (ifw.count_out !== 8'h93) begin failures++; $display("FAIL hold_steady got=%h exp=93", ifw.count_out); end
   endtask

   task automatic test_async_reset();
      drive(1'b1, 8'h47, 1'b0, 1'b1);
      tick();
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      tick();
      checks++; if (ifw.count_out !== 8'h47) begin failures++; $display("FAIL pre_reset got=%h exp=47", ifw.count_out); end
      checks++; if (ifw.zero !== 1'b0) begin failures++; $display("FAIL pre_reset_zero got=%b exp=0", ifw.zero); end
      #2 reset = 1'b0;
      #1;
      checks++; if (ifw.count_out !== 8'h00) begin failures++; $display("FAIL async_count got=%h exp=00", ifw.count_out); end
      checks++; if (ifw.zero !== 1'b1) begin failures++; $display("FAIL async_zero got=%b exp=1", ifw.zero); end
      checks++; if (ifw.tc_pulse !== 1'b0) begin failures++; $display("FAIL async_tc got=%b exp=0", ifw.tc_pulse); end
      #1 reset = 1'b1;
      drive(1'b0, 8'h00, 1'b1, 1'b1);
      tick();
      checks++; if (ifw.count_out !== 8'h00) begin failures++; $display("FAIL post_reset_a got=%h exp=00", ifw.count_out); end
      tick();
      checks++; if (ifw.count_out !== 8'h01) begin failures++; $display("FAIL post_reset_b got=%h exp=01", ifw.count_out); end
      drive(1'b0, 8'h00, 1'b0, 1'b1);
   endtask

`ifdef CNTM_FREEZE_EN
   task automatic test_freeze();
      int budget;
      drive(1'b1, 8'h10, 1'b0, 1'b1);
      tick();
      drive(1'b0, 8'h00, 1'b1, 1'b1);
      budget = 0;
      while (ifw.count_out !== 8'h12 && budget < 10) begin
         tick();
         budget++;
      end
      checks++; if (ifw.count_out !== 8'h12) begin failures++; $display("FAIL freeze_reach got=%h exp=12", ifw.count_out); end
      ifw.freeze = 1'b1;
      ifs.freeze = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++; if (ifw.count_out !== 8'h12) begin failures++; $display("FAIL freeze_hold k=%0d got=%h exp=12", k, ifw.count_out); end
         checks++; if (ifw.tc_pulse !== 1'b0) begin failures++; $display("FAIL freeze_tc k=%0d got=%b exp=0", k, ifw.tc_pulse); end
      end
      ifw.freeze = 1'b0;
      ifs.freeze = 1'b0;
      tick();
      checks++; if (ifw.count_out !== 8'h18) begin failures++; $display("FAIL freeze_resume got=%h exp=18", ifw.count_out); end
      drive(1'b0, 8'h00, 1'b0, 1'b1);
   endtask
`endif

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
`ifdef CNTM_FREEZE_EN
      ifw.freeze = 1'b0;
      ifs.freeze = 1'b0;
`endif
      test_reset();
      test_count_up();
      test_down_wrap();
      test_saturate();
      test_load_clamp();
      test_async_reset();
`ifdef CNTM_FREEZE_EN
      test_freeze();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
